// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: 16-bit read/write frames and 8-bit fast commands.
// Define SPI_REG_MASTER_STATUS_EN to capture the slave status byte on rsp_status.
module spi_reg_master #(
  parameter int DIV = 8,
  parameter int GAP = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] rsp_status,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic       nss,
  input  logic       miso
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LEAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_TRAIL    = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam int CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  // The IDLE cycle that accepts the next request is itself an nss-high cycle,
  // so the GAP state covers GAP-1 cycles to keep the high time at exactly GAP.
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 2);

`ifdef SPI_REG_MASTER_STATUS_EN
  localparam int RXW = 16;
`else
  localparam int RXW = 8;
`endif

  logic [2:0]     state_r;
  logic [2:0]     state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [3:0]     bit_cnt_r;
  logic [15:0]    tx_r;
  logic [RXW-1:0] rx_r;
  logic           fast_r;
  logic           ready_r;
  logic           busy_r;
  logic           sclk_r;
  logic           nss_r;
  logic           rsp_valid_r;
  logic [7:0]     rsp_rdata_r;
  logic           phase_end_s;
  logic           last_bit_s;

  // Phase termination and final-bit detection
  always_comb begin
    phase_end_s = 1'b0;
    case (state_r)
      ST_LEAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_TRAIL: phase_end_s = (cnt_r == DIV_LAST);
      ST_GAP:                                      phase_end_s = (cnt_r == GAP_LAST);
      default:                                     phase_end_s = 1'b0;
    endcase
    if (fast_r) begin
      last_bit_s = (bit_cnt_r == 4'd7);
    end else begin
      last_bit_s = (bit_cnt_r == 4'd15);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:     state_nxt_s = req_valid ? ST_LEAD : ST_IDLE;
      ST_LEAD:     state_nxt_s = phase_end_s ? ST_SHIFT_LO : ST_LEAD;
      ST_SHIFT_LO: state_nxt_s = phase_end_s ? ST_SHIFT_HI : ST_SHIFT_LO;
      ST_SHIFT_HI: state_nxt_s = phase_end_s ? (last_bit_s ? ST_TRAIL : ST_SHIFT_LO) : ST_SHIFT_HI;
      ST_TRAIL:    state_nxt_s = phase_end_s ? ST_GAP : ST_TRAIL;
      ST_GAP:      state_nxt_s = phase_end_s ? ST_IDLE : ST_GAP;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // State, phase counter and registered bus/handshake outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      sclk_r  <= 1'b0;
      nss_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      sclk_r  <= (state_nxt_s == ST_SHIFT_HI);
      nss_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_GAP);
    end
  end

  // Request latch, transmit/receive shifting and bit counting
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_r      <= 16'h0000;
      rx_r      <= '0;
      fast_r    <= 1'b0;
      bit_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            fast_r    <= (req_cmd == 2'b11);
            bit_cnt_r <= 4'd0;
            if (req_cmd == 2'b10) begin
              tx_r <= {req_cmd, req_addr, req_wdata};
            end else begin
              tx_r <= {req_cmd, req_addr, 8'h00};
            end
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end_s) begin
            rx_r <= {rx_r[RXW-2:0], miso};
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (!last_bit_s) begin
              tx_r <= {tx_r[14:0], 1'b0};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SPI_REG_MASTER_STATUS_EN
  logic [7:0] rsp_status_r;
`endif

  // Response capture at the end of TRAIL
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= 8'h00;
`ifdef SPI_REG_MASTER_STATUS_EN
      rsp_status_r <= 8'h00;
`endif
    end else begin
      rsp_valid_r <= 1'b0;
      if ((state_r == ST_TRAIL) && phase_end_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_rdata_r  <= fast_r ? 8'h00 : rx_r[7:0];
`ifdef SPI_REG_MASTER_STATUS_EN
        rsp_status_r <= fast_r ? rx_r[7:0] : rx_r[15:8];
`endif
      end
    end
  end

`ifdef SPI_REG_MASTER_STATUS_EN
  assign rsp_status = rsp_status_r;
`else
  assign rsp_status = 8'h00;
`endif

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign sclk      = sclk_r;
  assign nss       = nss_r;
  assign mosi      = tx_r[15];
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: SPI slave model plus frame-level reference expectations.
module tb_spi_reg_master;
  localparam int DIV = 8;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [5:0] req_addr = 6'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid, busy, sclk, mosi, nss;
  logic [7:0] rsp_rdata, rsp_status;
  logic       miso;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_reg_master #(.DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .busy(busy), .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso)
  );

  // Slave model and bus monitor, sampled on the inactive clock edge
  logic [15:0] slv_sh = 16'h0000;
  logic [15:0] mosi_cap = 16'h0000;
  logic [7:0]  slv_status = 8'h00;
  logic [7:0]  slv_reg = 8'h00;
  int rises = 0, nss_low = 0, vcount = 0, hi_run = 0, last_gap = 0;
  int mosi_viol = 0, ready_viol = 0;
  logic sclk_q = 1'b0, nss_q = 1'b1, mosi_q = 1'b0, nrst_q = 1'b0;

  always @(negedge clk) begin
    if (nrst && nrst_q) begin
      if ((mosi !== mosi_q) && !(sclk_q && !sclk) && !(nss_q && !nss)) mosi_viol++;
      if (!nss && req_ready) ready_viol++;
      if (busy === req_ready) ready_viol++;
    end
    if (nss_q && !nss) begin
      slv_sh   = {slv_status, slv_reg};
      rises    = 0;
      mosi_cap = 16'h0000;
      nss_low  = 0;
      last_gap = hi_run;
      hi_run   = 0;
    end
    if (nss) hi_run++;
    else nss_low++;
    if (!sclk_q && sclk) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (sclk_q && !sclk) slv_sh = {slv_sh[14:0], 1'b0};
    miso = slv_sh[15];
    if (rsp_valid) vcount++;
    sclk_q = sclk;
    nss_q  = nss;
    mosi_q = mosi;
    nrst_q = nrst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ready_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_rsp_timeout"}, 32'(got), 32'd1);
  endtask

  function automatic logic [7:0] exp_status(input logic [7:0] st);
`ifdef SPI_REG_MASTER_STATUS_EN
    return st;
`else
    return 8'h00;
`endif
  endfunction

  // One complete transaction checked against frame-level expectations
  task automatic run_req(input string tag, input logic [1:0] cmd, input logic [5:0] addr,
                         input logic [7:0] wdata, input logic [7:0] st, input logic [7:0] rg);
    logic [15:0] exp_mosi;
    int          nbits;
    int          v0;
    nbits    = (cmd == 2'b11) ? 8 : 16;
    exp_mosi = (cmd == 2'b11) ? {8'h00, cmd, addr}
                              : {cmd, addr, (cmd == 2'b10) ? wdata : 8'h00};
    slv_status = st;
    slv_reg    = rg;
    wait_ready(tag);
    req_cmd   = cmd;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    v0 = vcount;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    req_addr  = 6'($urandom);
    req_wdata = 8'($urandom);
    check({tag, "_nss_low_at_lead"}, 32'(nss), 32'd0);
    check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    check({tag, "_lead_mosi"}, 32'(mosi), 32'(exp_mosi[nbits-1]));
    wait_rsp(tag);
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'((cmd == 2'b11) ? 8'h00 : rg));
    check({tag, "_status"}, 32'(rsp_status), 32'(exp_status(st)));
    check({tag, "_nss_high_at_rsp"}, 32'(nss), 32'd1);
    @(negedge clk);
    check({tag, "_rsp_pulse_width"}, 32'(rsp_valid), 32'd0);
    wait_ready(tag);
    check({tag, "_mosi_bits"}, 32'(mosi_cap), 32'(exp_mosi));
    check({tag, "_sclk_rises"}, 32'(rises), 32'(nbits));
    check({tag, "_nss_low_len"}, 32'(nss_low), 32'((2 * nbits + 2) * DIV));
    check({tag, "_rsp_count"}, 32'(vcount - v0), 32'd1);
    check({tag, "_rdata_hold"}, 32'(rsp_rdata), 32'((cmd == 2'b11) ? 8'h00 : rg));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    logic got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_nss", 32'(nss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_status", 32'(rsp_status), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    // Directed transactions
    run_req("write05", 2'b10, 6'h05, 8'hA5, 8'h11, 8'h22);
    run_req("read03", 2'b00, 6'h03, 8'h77, 8'h5A, 8'h3C);
    run_req("fast2A", 2'b11, 6'h2A, 8'hFF, 8'hC7, 8'h81);
    run_req("reserved", 2'b01, 6'h3F, 8'h99, 8'h0F, 8'hF0);

    // Back-to-back reads with req_valid held
    slv_status = 8'hC3;
    slv_reg    = 8'h96;
    wait_ready("b2b");
    req_cmd   = 2'b00;
    req_addr  = 6'h12;
    req_valid = 1'b1;
    v0 = vcount;
    wait_rsp("b2b_first");
    check("b2b_first_rdata", 32'(rsp_rdata), 32'h96);
    wait_ready("b2b_second");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_second_nss", 32'(nss), 32'd0);
    wait_rsp("b2b_second");
    check("b2b_second_rdata", 32'(rsp_rdata), 32'h96);
    check("b2b_second_status", 32'(rsp_status), 32'(exp_status(8'hC3)));
    check("b2b_nss_gap", 32'(last_gap), 32'(GAP));
    wait_ready("b2b_end");
    check("b2b_rsp_count", 32'(vcount - v0), 32'd2);

    // Reset after the 5th sclk rise of a write
    wait_ready("abort");
    req_cmd   = 2'b10;
    req_addr  = 6'h21;
    req_wdata = 8'h5C;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rises >= 5) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_5_rises", 32'(got), 32'd1);
    v0 = vcount;
    #2;
    nrst = 1'b0;
    #1;
    check("abort_nss", 32'(nss), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_status", 32'(rsp_status), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rel_ready", 32'(req_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("abort_no_rsp", 32'(vcount - v0), 32'd0);
    run_req("after_abort", 2'b00, 6'h07, 8'h00, 8'hA1, 8'h1A);

    // Randomized transactions
    for (int n = 0; n < 8; n++) begin
      run_req($sformatf("rand%0d", n), 2'($urandom), 6'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
    end

    check("mosi_stability", 32'(mosi_viol), 32'd0);
    check("ready_busy_consistency", 32'(ready_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
